// File: rtl/mac_frame_sequencer.sv
// Job sequencer for one pipelined signed MAC: streams operand pairs from two sample RAMs,
// then captures the frame result. Optional job cycle counter: define MAC_SEQ_PERF_EN.
module mac_frame_sequencer #(
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 8,
  parameter int OUT_WIDTH   = 18,
  parameter int ADDR_WIDTH  = 8,
  parameter int MAC_LATENCY = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_a,
  input  logic [ADDR_WIDTH-1:0] i_base_b,
  input  logic [ADDR_WIDTH-1:0] i_len,
  output logic                  o_busy,
  output logic                  o_err,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_a,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_b,
  input  logic [A_WIDTH-1:0]    i_mem_data_a,
  input  logic [B_WIDTH-1:0]    i_mem_data_b,
  output logic [A_WIDTH-1:0]    o_mac_a,
  output logic [B_WIDTH-1:0]    o_mac_b,
  output logic                  o_mac_valid_in,
  output logic                  o_mac_eof,
  output logic                  o_mac_enable,
  output logic                  o_mac_reset,
  input  logic [OUT_WIDTH-1:0]  i_mac_result,
  output logic                  o_res_valid,
  output logic [OUT_WIDTH-1:0]  o_res_data,
  input  logic                  i_res_ready,
  output logic [15:0]           o_perf_cycles
);

  localparam int WAIT_W = $clog2(MAC_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_base_a;
  logic [ADDR_WIDTH-1:0] r_base_b;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_mac_valid;
  logic                  r_mac_eof;
  logic                  r_mac_reset;
  logic                  r_err;
  logic                  r_res_valid;
  logic [OUT_WIDTH-1:0]  r_res_data;

  logic w_accept;
  logic w_reject;
  logic w_last_issue;
  logic w_capture;
  logic w_issue;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_last_issue = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = i_start && (i_len != '0);
        w_reject = i_start && (i_len == '0);
        if (w_accept) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_issue      = 1'b1;
        w_last_issue = (r_remaining == ADDR_WIDTH'(1));
        if (w_last_issue) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // While the eof sample is on the MAC inputs the wait counter has not been loaded yet.
        w_capture = !r_mac_eof && (r_wait == '0);
        if (w_capture) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (i_res_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_remaining <= '0;
      r_idx       <= '0;
      r_wait      <= '0;
      r_mac_valid <= 1'b0;
      r_mac_eof   <= 1'b0;
      r_mac_reset <= 1'b1;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_mac_reset <= 1'b0;
      r_err       <= w_reject;
      r_mac_valid <= w_issue;
      r_mac_eof   <= w_last_issue;
      if (w_accept) begin
        r_base_a    <= i_base_a;
        r_base_b    <= i_base_b;
        r_remaining <= i_len;
        r_idx       <= '0;
      end else if (w_issue) begin
        r_remaining <= r_remaining - ADDR_WIDTH'(1);
        r_idx       <= r_idx + ADDR_WIDTH'(1);
      end
      if (r_mac_eof)           r_wait <= WAIT_W'(MAC_LATENCY);
      else if (r_wait != '0)   r_wait <= r_wait - WAIT_W'(1);
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= i_mac_result;
      end else if ((r_state == S_DONE) && i_res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_err          = r_err;
  assign o_mem_rd_en    = w_issue;
  assign o_mem_addr_a   = w_issue ? (r_base_a + r_idx) : '0;
  assign o_mem_addr_b   = w_issue ? (r_base_b + r_idx) : '0;
  // RAM data already arrives one cycle after the strobe, lining up with r_mac_valid.
  assign o_mac_a        = r_mac_valid ? i_mem_data_a : '0;
  assign o_mac_b        = r_mac_valid ? i_mem_data_b : '0;
  assign o_mac_valid_in = r_mac_valid;
  assign o_mac_eof      = r_mac_eof;
  assign o_mac_reset    = r_mac_reset;
  assign o_mac_enable   = !r_mac_reset;
  assign o_res_valid    = r_res_valid;
  assign o_res_data     = r_res_data;

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] r_perf;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                       r_perf <= '0;
    else if (w_accept)                                 r_perf <= '0;
    else if ((r_state != S_IDLE) && (r_perf != 16'hFFFF)) r_perf <= r_perf + 16'd1;
  end

  assign o_perf_cycles = r_perf;
`else
  assign o_perf_cycles = 16'd0;
`endif

endmodule

// File: doc/mac_frame_sequencer.md
Name: mac_frame_sequencer

Overview:
Job-level controller for the pipelined signed MAC core. It accepts a dot-product job with two base addresses and a length. It streams operand pairs from two synchronous sample RAMs into the MAC, with `valid_in`/`eof` framing. After the fixed pipeline latency it captures the accumulated frame result and hands it to the requester over a valid/ready handshake. It sits between the control/register layer and one MAC instance and owns that MAC exclusively.

Parameters:
- A_WIDTH, 8, operand A width (signed); matches MAC.
- B_WIDTH, 8, operand B width (signed); matches MAC.
- OUT_WIDTH, 18, MAC accumulator/result width.
- ADDR_WIDTH, 8, sample RAM address width; also job length width.
- MAC_LATENCY, 3, cycles from MAC input sample edge to updated MAC result (fixed at 3 for current MAC).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- base_a  in  ADDR_WIDTH  first address in RAM A.
- base_b  in  ADDR_WIDTH  first address in RAM B.
- len  in  ADDR_WIDTH  number of products; 0 is illegal.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse when start is seen with len==0.
- mem_rd_en  out  1  read strobe to both RAMs.
- mem_addr_a  out  ADDR_WIDTH  RAM A address.
- mem_addr_b  out  ADDR_WIDTH  RAM B address.
- mem_data_a  in  A_WIDTH  RAM A data; valid 1 cycle after mem_rd_en.
- mem_data_b  in  B_WIDTH  RAM B data; valid 1 cycle after mem_rd_en.
- mac_a  out  A_WIDTH  operand A to the MAC.
- mac_b  out  B_WIDTH  operand B to the MAC.
- mac_valid_in  out  1  MAC sample valid.
- mac_eof  out  1  MAC last-sample flag.
- mac_enable  out  1  MAC clock enable.
- mac_reset  out  1  MAC synchronous reset.
- mac_result  in  OUT_WIDTH  MAC accumulator output.
- res_valid  out  1  job result available.
- res_data  out  OUT_WIDTH  captured signed dot product.
- res_ready  in  1  consumer accepts the result.
- perf_cycles  out  16  job cycle count; see Optional Feature.

Behaviour:
- Reset (async assert, sync release). All outputs are 0 except mac_reset=1. FSM goes to IDLE.
- mac_reset is a register: 1 during reset and for the first clock edge after release, then 0. This flushes stale MAC pipeline state so the first sample starts a fresh frame.
- mac_enable is always 1 once mac_reset is 0. The sequencer never stalls the MAC.
- IDLE:
  - start && len!=0: latch bases and len, load remaining=len, go to ISSUE.
  - start && len==0: err=1 for one cycle, stay in IDLE.
- ISSUE:
  - Each cycle: mem_rd_en=1, addr_a/addr_b = base+index. Addresses wrap modulo 2^ADDR_WIDTH; no error on wrap.
  - Decrement remaining each cycle. Go to DRAIN on the cycle that issues the last address (remaining==1).
  - Exactly len consecutive read cycles, with no bubbles.
- MAC feed:
  - Registered one cycle behind mem_rd_en: mac_valid_in = mem_rd_en delayed 1.
  - mac_a/mac_b = mem_data_a/mem_data_b, passed through with no extra register because the RAM is already 1-cycle.
  - mac_eof=1 only with the last sample.
  - With mac_valid_in=0, mac_a/mac_b/mac_eof are held at 0.
- DRAIN:
  - Wait counter loads MAC_LATENCY when the last sample is presented to the MAC.
  - At 0, capture mac_result into res_data, set res_valid=1, go to DONE.
  - Total latency: start accept to res_valid = len + 1 + MAC_LATENCY + 1 cycles (len=4 → 9).
- DONE:
  - res_valid and res_data held stable until res_ready. Back-to-back jobs are blocked; start is ignored.
  - res_valid && res_ready: res_valid=0 on the next edge, go to IDLE.
  - A new start is accepted at the earliest the cycle after returning to IDLE.
- Arithmetic: no widening or saturation; res_data is exactly the MAC's OUT_WIDTH two's-complement sum.
- Simultaneous events:
  - start while busy: ignored, with no err.
  - res_ready while not in DONE: ignored.
- Reset mid-job: immediate return to IDLE, res_valid=0, mac_reset re-asserted. No partial result is ever emitted.

Optional Feature:
- Macro: MAC_SEQ_PERF_EN.
- Defined: perf_cycles clears on start accept. It increments every cycle while busy and saturates at 16'hFFFF. It holds its value in IDLE until the next accept.
- Undefined: the counter is not built and perf_cycles is tied to 0.
- Ports are identical in both builds.

Test Plan:
- Post-reset: mac_reset=1 for one edge after release, all other outputs 0. start with len=0 → err pulse of 1 cycle, busy stays 0.
- A=[1,2,3,4], B=[5,6,7,8] at base 0, len=4 → res_data=70, res_valid 9 cycles after start. perf_cycles=9 with MAC_SEQ_PERF_EN.
- Signed job: A=[-128,-128], B=[127,-128], len=2 → res_data=128. Then len=1 with A=[-1], B=[1] → res_data=-1, confirming the frame restarts.
- Address wrap: base_a=254, base_b=0, len=4, ADDR_WIDTH=8 → A read from addresses 254, 255, 0, 1; result matches the golden model.
- Backpressure: hold res_ready=0 for 5 cycles → res_valid and res_data stable, start ignored. res_ready=1 → IDLE next cycle.
- Assert reset mid-ISSUE of a len=8 job → outputs reset immediately. A following len=2 job gives the correct result, with no contamination from the aborted job.
